// File: rtl/line_window_assembler.sv
// Assembles K-pixel input columns into a KxK sliding window and tracks raster position.
// A window is presented only when every element lies inside the current frame.
module line_window_assembler #(
  parameter int Width       = 8,
  parameter int KernelSize  = 3,
  parameter int FrameWidth  = 640,
  parameter int FrameHeight = 480
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [Width*KernelSize-1:0]              data_i,
  input  logic                                     valid_i,
  output logic                                     ready_o,
  output logic [Width*KernelSize*KernelSize-1:0]   window_o,
  output logic                                     valid_o,
  input  logic                                     ready_i,
  output logic [$clog2(FrameWidth)-1:0]            x_o,
  output logic [$clog2(FrameHeight)-1:0]           y_o
);

  localparam int XW = $clog2(FrameWidth);
  localparam int YW = $clog2(FrameHeight);
  localparam int K  = KernelSize;

  localparam logic [XW-1:0] XLast = XW'(FrameWidth - 1);
  localparam logic [YW-1:0] YLast = YW'(FrameHeight - 1);
  localparam logic [XW-1:0] XMin  = XW'(KernelSize - 1);
  localparam logic [YW-1:0] YMin  = YW'(KernelSize - 1);

  logic [XW-1:0]            x_r;
  logic [YW-1:0]            y_r;
  logic                     in_fire;
  logic                     complete;
  logic [Width*K*K-1:0]     win_shift;

  assign ready_o  = !valid_o || ready_i;
  assign in_fire  = valid_i && ready_o;
  assign complete = (x_r >= XMin) && (y_r >= YMin);

  // Top row (r=0) takes the oldest slot so rows read top-to-bottom in raster order.
  always_comb begin
    win_shift = window_o;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        win_shift[(r*K+c)*Width +: Width] = window_o[(r*K+c+1)*Width +: Width];
      end
      win_shift[(r*K+K-1)*Width +: Width] = data_i[(K-1-r)*Width +: Width];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_r      <= '0;
      y_r      <= '0;
      window_o <= '0;
      valid_o  <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
    end else if (in_fire) begin
      window_o <= win_shift;
      valid_o  <= complete;
      x_o      <= x_r;
      y_o      <= y_r;
      if (x_r == XLast) begin
        x_r <= '0;
        y_r <= (y_r == YLast) ? '0 : y_r + 1'b1;
      end else begin
        x_r <= x_r + 1'b1;
      end
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window_assembler.sv
// Directed bench for line_window_assembler with a 5x4 frame and 3x3 window.
module tb_line_window_assembler;

  localparam int W = 8, K = 3, FW = 5, FH = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [W*K-1:0]  data_i;
  logic            valid_i;
  logic            ready_o;
  logic [W*K*K-1:0] window_o;
  logic            valid_o;
  logic            ready_i;
  logic [2:0]      x_o;
  logic [1:0]      y_o;

  int checks = 0;
  int failures = 0;

  line_window_assembler #(.Width(W), .KernelSize(K), .FrameWidth(FW), .FrameHeight(FH)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .window_o(window_o), .valid_o(valid_o), .ready_i(ready_i), .x_o(x_o), .y_o(y_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [W*K-1:0] col(input int x, input int y);
    logic [W*K-1:0] v;
    for (int i = 0; i < K; i++) v[i*W +: W] = 8'(16*(y-i) + x);
    return v;
  endfunction

  // Element (r,c) of the window whose newest column is (x,y).
  function automatic logic [W*K*K-1:0] exp_win(input int x, input int y);
    logic [W*K*K-1:0] v;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*W +: W] = 8'(16*(y-2+r) + x-2+c);
    return v;
  endfunction

  task automatic step_col(input int x, input int y);
    data_i  = col(x, y);
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #3;
    rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
    checks++; if (window_o !== '0) begin failures++; $display("FAIL reset_window: got %h expected 0", window_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (x_o !== 3'd0 || y_o !== 2'd0) begin failures++; $display("FAIL reset_xy: got %0d,%0d expected 0,0", x_o, y_o); end
    rst_i = 1'b0;
    @(posedge clk); #1;
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x < FW; x++)
        if (y < 2 || x <= 2) step_col(x, y);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL pre_reset_valid: got %b expected 1", valid_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL async_reset_valid: got %b expected 0", valid_o); end
    checks++; if (window_o !== '0) begin failures++; $display("FAIL async_reset_window: got %h expected 0", window_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL async_reset_ready: got %b expected 1", ready_o); end
    #2 rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame();
    int wins = 0;
    logic ev;
    do_reset();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) begin
        step_col(x, y);
        ev = (x >= 2 && y >= 2);
        checks++; if (valid_o !== ev) begin failures++; $display("FAIL full_valid(%0d,%0d): got %b expected %b", x, y, valid_o, ev); end
        if (ev) begin
          wins++;
          checks++; if (window_o !== exp_win(x, y)) begin failures++; $display("FAIL full_window(%0d,%0d): got %h expected %h", x, y, window_o, exp_win(x, y)); end
          checks++; if (x_o !== 3'(x) || y_o !== 2'(y)) begin failures++; $display("FAIL full_xy: got %0d,%0d expected %0d,%0d", x_o, y_o, x, y); end
        end
        if (x == 2 && y == 2) begin
          checks++; if (window_o[7:0] !== 8'h00) begin failures++; $display("FAIL first_e00: got %h expected 00", window_o[7:0]); end
          checks++; if (window_o[71:64] !== 8'h22) begin failures++; $display("FAIL first_e22: got %h expected 22", window_o[71:64]); end
        end
      end
    checks++; if (wins != 6) begin failures++; $display("FAIL full_count: got %0d expected 6", wins); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL full_idle_clear: got %b expected 0", valid_o); end
  endtask

  task automatic test_row_wrap();
    do_reset();
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x < FW; x++) step_col(x, y);
    step_col(0, 3);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL wrap_col0: got %b expected 0", valid_o); end
    step_col(1, 3);
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL wrap_col1: got %b expected 0", valid_o); end
    step_col(2, 3);
    checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL wrap_col2_valid: got %b expected 1", valid_o); end
    checks++; if (window_o[55:48] !== 8'h30) begin failures++; $display("FAIL wrap_e20: got %h expected 30", window_o[55:48]); end
    checks++; if (window_o[23:16] !== 8'h12) begin failures++; $display("FAIL wrap_e02: got %h expected 12", window_o[23:16]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int y = 0; y <= 2; y++)
      for (int x = 0; x < FW; x++)
        if (y < 2 || x <= 3) step_col(x, y);
    ready_i = 1'b0;
    data_i  = col(4, 2);
    valid_i = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b expected 0", ready_o); end
      checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b expected 1", valid_o); end
      checks++; if (window_o !== exp_win(3, 2)) begin failures++; $display("FAIL bp_window: got %h expected %h", window_o, exp_win(3, 2)); end
      checks++; if (x_o !== 3'd3 || y_o !== 2'd2) begin failures++; $display("FAIL bp_xy: got %0d,%0d expected 3,2", x_o, y_o); end
    end
    ready_i = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL bp_release_ready: got %b expected 1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++; if (valid_o !== 1'b1 || x_o !== 3'd4 || y_o !== 2'd2) begin failures++; $display("FAIL bp_next: got v=%b x=%0d y=%0d expected v=1 x=4 y=2", valid_o, x_o, y_o); end
    checks++; if (window_o !== exp_win(4, 2)) begin failures++; $display("FAIL bp_next_window: got %h expected %h", window_o, exp_win(4, 2)); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b expected 0", valid_o); end
  endtask

  task automatic test_frame_wrap();
    int wins = 0;
    int wins2 = 0;
    logic ev;
    do_reset();
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < FH; y++)
        for (int x = 0; x < FW; x++) begin
          step_col(x, y);
          ev = (x >= 2 && y >= 2);
          checks++; if (valid_o !== ev) begin failures++; $display("FAIL fw_valid(f%0d,%0d,%0d): got %b expected %b", f, x, y, valid_o, ev); end
          if (ev) begin
            wins++;
            if (f == 1) wins2++;
          end
          if (f == 1 && x == 0 && y == 0) begin
            checks++; if (x_o !== 3'd0 || y_o !== 2'd0) begin failures++; $display("FAIL fw_origin: got %0d,%0d expected 0,0", x_o, y_o); end
          end
          if (f == 1 && x == 2 && y == 2) begin
            checks++; if (window_o !== exp_win(2, 2) || x_o !== 3'd2 || y_o !== 2'd2) begin failures++; $display("FAIL fw_first2: got %h at %0d,%0d expected %h at 2,2", window_o, x_o, y_o, exp_win(2, 2)); end
          end
        end
    checks++; if (wins != 12) begin failures++; $display("FAIL fw_count: got %0d expected 12", wins); end
    checks++; if (wins2 != 6) begin failures++; $display("FAIL fw_count2: got %0d expected 6", wins2); end
  endtask

  task automatic test_bubbles();
    int wins = 0;
    logic ev;
    do_reset();
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < FW; x++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          checks++; if (valid_o !== 1'b0) begin failures++; $display("FAIL bub_idle: got %b expected 0", valid_o); end
        end
        step_col(x, y);
        ev = (x >= 2 && y >= 2);
        checks++; if (valid_o !== ev) begin failures++; $display("FAIL bub_valid(%0d,%0d): got %b expected %b", x, y, valid_o, ev); end
        if (ev) begin
          wins++;
          checks++; if (window_o !== exp_win(x, y) || x_o !== 3'(x) || y_o !== 2'(y)) begin failures++; $display("FAIL bub_window(%0d,%0d): got %h at %0d,%0d expected %h", x, y, window_o, x_o, y_o, exp_win(x, y)); end
        end
      end
    checks++; if (wins != 6) begin failures++; $display("FAIL bub_count: got %0d expected 6", wins); end
  endtask

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    #12;
    test_reset();
    test_full_frame();
    test_row_wrap();
    test_backpressure();
    test_frame_wrap();
    test_bubbles();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_assembler.md
# line_window_assembler

Consumer for the stacked-column stream produced by the line-buffer delay block. Each accepted input beat is one vertical column of `KernelSize` pixels. The block shifts these columns horizontally into a `KernelSize` x `KernelSize` window register, tracks raster position, and presents a registered window only when the window lies fully inside the frame. Its output feeds the convolution/filter kernels.

## Interface
- `Width`, default 8: bits per pixel.
- `KernelSize`, default 3: window side K; must equal the line buffer's buffer count; K >= 2.
- `FrameWidth`, default 640: pixels per row; must be >= K.
- `FrameHeight`, default 480: rows per frame; must be >= K.
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-high.
- `data_i`, in, Width*K: input column. Slot i (bits [Width*(i+1)-1 : Width*i]) is the pixel from i rows ago; slot 0 is the current row.
- `valid_i`, in, 1: column valid.
- `ready_o`, out, 1: column accepted when `valid_i && ready_o`.
- `window_o`, out, Width*K*K: element (r,c) sits at bit offset (r*K+c)*Width.
  - r=0 is the top (oldest) row; c=0 is the leftmost (oldest) column.
- `valid_o`, out, 1: window valid.
- `ready_i`, in, 1: downstream accept.
- `x_o`, out, $clog2(FrameWidth): column index of the newest column in the current window.
- `y_o`, out, $clog2(FrameHeight): row index of the current row.

## Operation
- `in_fire = valid_i && ready_o`. `ready_o = !valid_o || ready_i` (combinational).
- On `in_fire`, the window shifts left by one column.
  - Element (r,c) takes element (r,c+1) for c < K-1.
  - Element (r,K-1) takes `data_i` slot K-1-r, so the top row gets the oldest slot.
- Raster counters `x_r`/`y_r` hold the position of the column being accepted.
  - On `in_fire`, `x_r` increments.
  - When `x_r == FrameWidth-1`, `x_r` wraps to 0 and `y_r` increments.
  - When `y_r == FrameHeight-1` at the same time, `y_r` also wraps to 0.
- Window-complete condition: `x_r >= K-1 && y_r >= K-1`, evaluated on the pre-increment values of the accepted column.
- On `in_fire`:
  - `valid_o` is set to the window-complete condition.
  - `x_o`/`y_o` capture the pre-increment `x_r`/`y_r`.
- If there is no `in_fire` and `ready_i` is high, `valid_o` clears.
- If `valid_o && !ready_i`:
  - `ready_o` is low.
  - `window_o`, `x_o`, `y_o` and `valid_o` hold unchanged.
- Stale columns from the previous row remain in the window during columns 0..K-2 of a new row. They are never exposed, because `valid_o` is 0 for those columns.
- No arithmetic beyond the counters. Counters are sized by $clog2 of their limits and compare against `FrameWidth-1` / `FrameHeight-1` cast to counter width.

## Timing
- Reset values:
  - `valid_o` = 0.
  - `window_o` = all zeros.
  - `x_o`, `y_o`, `x_r`, `y_r` = 0.
  - `ready_o` = 1 after reset, since it is derived from `valid_o` = 0.
- Latency: a window is presented 1 cycle after the `in_fire` of its newest column.
- Throughput: 1 column per cycle when `ready_i` is held high.
  - Simultaneous output accept and new input in the same cycle is legal and sustains full rate.
- Reset mid-frame returns the block to position (0,0) with `valid_o` = 0. A window in flight is lost.
- `valid_o` must not drop while `ready_i` is low. `window_o` must be stable while `valid_o && !ready_i`.
- Frame boundary: the cycle after the `in_fire` at (FrameWidth-1, FrameHeight-1), `x_r` and `y_r` are both 0.
  - The next frame's first K-1 rows produce no windows.

## Test plan
Parameters for all scenarios unless noted: Width=8, K=3, FrameWidth=5, FrameHeight=4. Slot i of column (x,y) = 8'(16*(y-i)+x).

- **Reset:** assert `rst_i` asynchronously mid-cycle -> `valid_o`=0, `window_o`=0, `ready_o`=1 immediately, with no clock edge needed.
- **Full frame, `ready_i`=1:** stream 20 columns -> exactly 6 windows, at (x,y) ∈ {2,3,4}×{2,3}.
  - The first window arrives one cycle after column (2,2) and has element (0,0)=8'h00 and element (2,2)=8'h22.
- **Row wrap:** after column (4,2), feed columns (0,3) and (1,3) -> `valid_o`=0 for both.
  - Column (2,3) yields element (2,0)=8'h30 and element (0,2)=8'h12.
- **Backpressure:** hold `ready_i`=0 while the window at (3,2) is valid for 5 cycles -> `ready_o`=0, and `window_o`, `x_o`=3, `y_o`=2 stay stable.
  - Releasing `ready_i` delivers the window once; the next input is accepted that same cycle.
- **Frame wrap:** stream two back-to-back frames -> 12 windows total.
  - The second frame's first window is at (2,2); none appear during its first two rows.
- **Bubbles:** toggle `valid_i` randomly -> same window set and values as the full-rate frame.
